// File: rtl/tlp_demux_n_pkg.sv
// Shared TLP definitions: class and FSM encodings, Fmt/Type field positions,
// and the DW0 class decode used by both receive and transmit paths.
package tlp_pkg;

    typedef enum logic [2:0] {
        MRD   = 3'd0,
        MWR   = 3'd1,
        CPL   = 3'd2,
        MSG   = 3'd3,
        UNSUP = 3'd4
    } tlp_class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

    localparam int NUM_CLASSES = 4;
    localparam int FMT_MSB     = 31;
    localparam int FMT_LSB     = 29;
    localparam int TYPE_MSB    = 28;
    localparam int TYPE_LSB    = 24;

    function automatic tlp_class_e tlp_class(input logic [31:0] hdr_dw0);
        logic [2:0] fmt;
        logic [4:0] typ;
        fmt = hdr_dw0[FMT_MSB:FMT_LSB];
        typ = hdr_dw0[TYPE_MSB:TYPE_LSB];
        if (typ == 5'b00000 && fmt[2:1] == 2'b00) begin
            return MRD;
        end else if (typ == 5'b00000 && fmt[2:1] == 2'b01) begin
            return MWR;
        end else if (typ == 5'b01010) begin
            return CPL;
        end else if (typ[4:3] == 2'b10) begin
            return MSG;
        end
        return UNSUP;
    endfunction

endpackage

// File: rtl/tlp_demux_n_if.sv
// Receive stream in, per-port request streams out. The demux uses the slave
// view; the packet source/sink side uses the master view.
interface tlp_demux_n_if #(
    parameter int PORTS          = 4,
    parameter int HEADER_SIZE    = 128,
    parameter int TLP_DATA_WIDTH = 256
);
    logic [TLP_DATA_WIDTH-1:0]       in_data;
    logic [HEADER_SIZE-1:0]          in_hdr;
    logic                            in_sop;
    logic                            in_eop;
    logic                            in_valid;
    logic                            in_ready;
    logic [PORTS*TLP_DATA_WIDTH-1:0] out_data;
    logic [PORTS*HEADER_SIZE-1:0]    out_hdr;
    logic [PORTS-1:0]                out_sop;
    logic [PORTS-1:0]                out_eop;
    logic [PORTS-1:0]                out_valid;
    logic [PORTS-1:0]                out_ready;

    modport master (
        output in_data, in_hdr, in_sop, in_eop, in_valid, out_ready,
        input  in_ready, out_data, out_hdr, out_sop, out_eop, out_valid
    );

    modport slave (
        input  in_data, in_hdr, in_sop, in_eop, in_valid, out_ready,
        output in_ready, out_data, out_hdr, out_sop, out_eop, out_valid
    );
endinterface

// File: rtl/tlp_demux_n_class_dec.sv
// Combinational DW0 classifier: enum class plus a one-hot valid per class
// (all zero for unsupported TLPs).
module tlp_class_dec
    import tlp_pkg::*;
(
    input  logic [31:0]            dw0_i,
    output tlp_class_e             cls_o,
    output logic [NUM_CLASSES-1:0] cls_oh_o
);

    assign cls_o = tlp_class(dw0_i);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_oh
            assign cls_oh_o[gi] = (int'(cls_o) == gi);
        end
    endgenerate

endmodule

// File: rtl/tlp_demux_n.sv
// N-port TLP demultiplexer: decodes class on sop, locks the route for the
// packet and forwards beats through a single registered output slot.
module tlp_demux_n
    import tlp_pkg::*;
#(
    parameter int PORTS          = 4,
    parameter int DOUBLE_WORD    = 32,
    parameter int HEADER_SIZE    = 4*DOUBLE_WORD,
    parameter int TLP_DATA_WIDTH = 8*DOUBLE_WORD,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    tlp_demux_n_if.slave     bus,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PSEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [NUM_CLASSES-1:0] PORT_MASK = NUM_CLASSES'((1 << PORTS) - 1);

    state_e                    state_q, state_d;
    logic [PSEL_W-1:0]         port_sel_q, port_sel_d;
    logic [HEADER_SIZE-1:0]    hdr_q, hdr_d;
    logic [TLP_DATA_WIDTH-1:0] data_q, data_d;
    logic                      slot_valid_q, slot_valid_d;
    logic                      slot_sop_q, slot_sop_d;
    logic                      slot_eop_q, slot_eop_d;
    logic [CNT_W-1:0]          drop_q, drop_d;
    logic [CNT_W-1:0]          err_q, err_d;

    tlp_class_e                cls;
    logic [NUM_CLASSES-1:0]    cls_oh;
    logic                      mapped, drain, in_ready_c, accept;
    logic                      fwd_beat, latch_hdr, do_drop, do_err;

    tlp_class_dec u_dec (
        .dw0_i    (bus.in_hdr[DOUBLE_WORD-1:0]),
        .cls_o    (cls),
        .cls_oh_o (cls_oh)
    );

    assign mapped = |(cls_oh & PORT_MASK);
    // The slot can take a new beat if it is empty or its beat leaves this edge.
    assign drain  = ~slot_valid_q | bus.out_ready[port_sel_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && bus.in_sop && !bus.in_eop) begin
                    state_d = mapped ? FWD : DROP;
                end
            end
            FWD, DROP: begin
                if (accept && bus.in_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unique case (state_q)
            IDLE:    in_ready_c = enable & drain;
            FWD:     in_ready_c = drain;
            DROP:    in_ready_c = 1'b1;
            default: in_ready_c = 1'b0;
        endcase
        in_ready_c = in_ready_c & ~rst;
        accept     = bus.in_valid & in_ready_c;
        latch_hdr  = accept & (state_q == IDLE) & bus.in_sop & mapped;
        fwd_beat   = latch_hdr | (accept & (state_q == FWD));
        do_drop    = accept & (state_q == IDLE) & bus.in_sop & ~mapped;
        // A sop inside a packet is a framing error but travels on as payload.
        do_err     = accept & ((state_q == IDLE) ? ~bus.in_sop : bus.in_sop);
    end

    assign bus.in_ready = in_ready_c;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_sop_d   = slot_sop_q;
        slot_eop_d   = slot_eop_q;
        data_d       = data_q;
        hdr_d        = hdr_q;
        port_sel_d   = port_sel_q;
        drop_d       = drop_q;
        err_d        = err_q;
        if (fwd_beat) begin
            slot_valid_d = 1'b1;
            slot_sop_d   = (state_q == IDLE);
            slot_eop_d   = bus.in_eop;
            data_d       = bus.in_data;
        end else if (slot_valid_q && bus.out_ready[port_sel_q]) begin
            slot_valid_d = 1'b0;
        end
        if (latch_hdr) begin
            hdr_d      = bus.in_hdr;
            port_sel_d = PSEL_W'(cls);
        end
        if (do_drop && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
        if (do_err && err_q != '1) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_sop_q   <= 1'b0;
            slot_eop_q   <= 1'b0;
            data_q       <= '0;
            hdr_q        <= '0;
            port_sel_q   <= '0;
            drop_q       <= '0;
            err_q        <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_sop_q   <= slot_sop_d;
            slot_eop_q   <= slot_eop_d;
            data_q       <= data_d;
            hdr_q        <= hdr_d;
            port_sel_q   <= port_sel_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
        end
    end

    assign drop_cnt = drop_q;
    assign err_cnt  = err_q;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            logic sel;
            assign sel                = (port_sel_q == PSEL_W'(gi));
            assign bus.out_valid[gi]  = slot_valid_q & sel;
            assign bus.out_sop[gi]    = slot_valid_q & slot_sop_q & sel;
            assign bus.out_eop[gi]    = slot_valid_q & slot_eop_q & sel;
            assign bus.out_data[gi*TLP_DATA_WIDTH +: TLP_DATA_WIDTH] = sel ? data_q : '0;
            assign bus.out_hdr[gi*HEADER_SIZE +: HEADER_SIZE]        = sel ? hdr_q  : '0;
        end
    endgenerate

endmodule

// File: tb/tb_tlp_demux_n.sv
// Directed bench for tlp_demux_n with a packet-level reference model and a
// per-cycle compare process on the falling edge.
module tb_tlp_demux_n;

    localparam int P  = 3;
    localparam int DW = 256;
    localparam int HW = 128;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [HW-1:0] H_MRD  = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'h0000_0004};
    localparam logic [HW-1:0] H_MRD4 = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'h2000_0004};
    localparam logic [HW-1:0] H_MWR  = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'h4000_0002};
    localparam logic [HW-1:0] H_CPLD = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'h4A00_0002};
    localparam logic [HW-1:0] H_MSG  = {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'h3000_0000};
    localparam logic [HW-1:0] H_UNS  = {32'hF3F3_0003, 32'hF2F2_0002, 32'hF1F1_0001, 32'h0400_0001};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          rdy_toggle = 1'b0;
    logic [CW-1:0] drop_cnt, err_cnt;
    int            tests = 0;
    int            fails = 0;
    int            stalls = 0;
    int            rx_cnt [P];

    tlp_demux_n_if #(.PORTS(P), .HEADER_SIZE(HW), .TLP_DATA_WIDTH(DW)) bus ();

    tlp_demux_n #(.PORTS(P), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus),
        .drop_cnt (drop_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Class from the Fmt/Type rules; -1 means unsupported.
    function automatic int cls_of(input logic [HW-1:0] h);
        logic [2:0] f;
        logic [4:0] t;
        f = h[31:29];
        t = h[28:24];
        if (t == 5'b00000 && (f == 3'b000 || f == 3'b001)) return 0;
        if (t == 5'b00000 && (f == 3'b010 || f == 3'b011)) return 1;
        if (t == 5'b01010) return 2;
        if (t[4:3] == 2'b10) return 3;
        return -1;
    endfunction

    typedef struct {
        logic [1:0]    port;
        logic [DW-1:0] d;
        logic [HW-1:0] h;
        logic          s;
        logic          e;
    } beat_t;

    beat_t         exp_q [$];
    int            m_mode = 0;  // 0 between packets, 1 forwarding, 2 dropping
    logic [1:0]    m_port = '0;
    logic [HW-1:0] m_hdr = '0;
    int            m_drop = 0;
    int            m_err = 0;

    initial begin
        beat_t b;
        logic  ev, drain_ok, exp_rdy;
        int    c;
        for (int p = 0; p < P; p++) rx_cnt[p] = 0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < P; p++) begin
                ev = (exp_q.size() != 0) && (exp_q[0].port == p);
                chk($sformatf("out_valid[%0d]", p), bus.out_valid[p], ev);
                if (ev && bus.out_valid[p]) begin
                    chk($sformatf("out_data[%0d]", p), bus.out_data[p*DW +: DW], exp_q[0].d);
                    chk($sformatf("out_hdr[%0d]", p), bus.out_hdr[p*HW +: HW], exp_q[0].h);
                    chk($sformatf("out_sop[%0d]", p), bus.out_sop[p], exp_q[0].s);
                    chk($sformatf("out_eop[%0d]", p), bus.out_eop[p], exp_q[0].e);
                end
            end
            drain_ok = (exp_q.size() == 0) || bus.out_ready[exp_q[0].port];
            exp_rdy  = rst ? 1'b0 : (m_mode == 2) ? 1'b1 :
                       (m_mode == 1) ? drain_ok : (enable && drain_ok);
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("err_cnt", err_cnt, m_err);
            if (rst) begin
                exp_q.delete();
                m_mode = 0;
                m_drop = 0;
                m_err  = 0;
            end else begin
                if (exp_q.size() != 0 && bus.out_ready[exp_q[0].port]) begin
                    rx_cnt[exp_q[0].port]++;
                    void'(exp_q.pop_front());
                end
                if (bus.in_valid && exp_rdy) begin
                    $display("[TB] t=%0t beat data=%04h sop=%0b eop=%0b mode=%0d",
                             $time, bus.in_data[15:0], bus.in_sop, bus.in_eop, m_mode);
                    if (m_mode == 0) begin
                        if (!bus.in_sop) begin
                            if (m_err < CMAX) m_err++;
                        end else begin
                            c = cls_of(bus.in_hdr);
                            if (c >= 0 && c < P) begin
                                m_port = 2'(c);
                                m_hdr  = bus.in_hdr;
                                b = '{port: m_port, d: bus.in_data, h: m_hdr, s: 1'b1, e: bus.in_eop};
                                exp_q.push_back(b);
                                m_mode = bus.in_eop ? 0 : 1;
                            end else begin
                                if (m_drop < CMAX) m_drop++;
                                m_mode = bus.in_eop ? 0 : 2;
                            end
                        end
                    end else begin
                        if (bus.in_sop && m_err < CMAX) m_err++;
                        if (m_mode == 1) begin
                            b = '{port: m_port, d: bus.in_data, h: m_hdr, s: 1'b0, e: bus.in_eop};
                            exp_q.push_back(b);
                        end
                        if (bus.in_eop) m_mode = 0;
                    end
                end
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        bus.out_ready = '1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) begin
                bus.out_ready[0] = (ph == 0);
                ph = (ph + 1) % 5;
            end else begin
                bus.out_ready = '1;
                ph = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [HW-1:0] h, input logic s, input logic e);
        int k;
        bus.in_data  = d;
        bus.in_hdr   = h;
        bus.in_sop   = s;
        bus.in_eop   = e;
        bus.in_valid = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            stalls++;
            k++;
            if (k > 100) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: in_ready stayed 0, required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic send_pkt(input logic [HW-1:0] h, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            send_beat(base + DW'(i), h, i == 0, i == n - 1);
        end
    endtask

    initial begin
        int k;
        bus.in_data  = '0;
        bus.in_hdr   = '0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_valid = 1'b0;
        idle(3);
        chk("reset_out_valid", bus.out_valid, 0);
        rst    = 1'b0;
        enable = 1'b1;

        // Back-to-back MRd (3) then MWr (2) with all ports ready.
        stalls = 0;
        send_pkt(H_MRD, 3, 'h100);
        send_pkt(H_MWR, 2, 'h200);
        chk("t1_stalls", stalls, 0);
        idle(3);
        chk("t1_rx_p0", rx_cnt[0], 3);
        chk("t1_rx_p1", rx_cnt[1], 2);

        // CplD routes to port 2; Msg is unmapped at P=3; CfgRd is unsupported.
        stalls = 0;
        send_pkt(H_CPLD, 2, 'h280);
        send_pkt(H_MSG, 2, 'h290);
        send_pkt(H_UNS, 1, 'h2A0);
        chk("t2_stalls", stalls, 0);
        idle(3);
        chk("t2_rx_p2", rx_cnt[2], 2);
        chk("t2_drop", drop_cnt, 2);

        // Port 0 ready pulses one cycle in five over a 4-beat MRd.
        rdy_toggle = 1'b1;
        send_pkt(H_MRD4, 4, 'h300);
        k = 0;
        while (rx_cnt[0] < 7 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        rdy_toggle = 1'b0;
        chk("t3_rx_p0", rx_cnt[0], 7);
        idle(2);

        // Stray non-sop beat in idle, then a sop inside a forwarded packet.
        send_beat('h400, H_MRD, 1'b0, 1'b0);
        send_beat('h410, H_MRD, 1'b1, 1'b0);
        send_beat('h411, H_MWR, 1'b1, 1'b0);
        send_beat('h412, H_MRD, 1'b0, 1'b1);
        idle(3);
        chk("t4_err", err_cnt, 2);
        chk("t4_rx_p0", rx_cnt[0], 10);

        // Enable drops after beat 1 of an MWr; the packet still completes.
        send_beat('h500, H_MWR, 1'b1, 1'b0);
        enable = 1'b0;
        send_beat('h501, H_MWR, 1'b0, 1'b0);
        send_beat('h502, H_MWR, 1'b0, 1'b0);
        send_beat('h503, H_MWR, 1'b0, 1'b1);
        idle(3);
        chk("t5_rx_p1", rx_cnt[1], 6);
        bus.in_data  = 'h510;
        bus.in_hdr   = H_MRD;
        bus.in_sop   = 1'b1;
        bus.in_eop   = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_blocked", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        send_beat('h510, H_MRD, 1'b1, 1'b1);
        idle(3);
        chk("t5_rx_p0", rx_cnt[0], 11);

        // Reset on beat 2 of a 3-beat MRd, then a fresh MRd.
        send_beat('h600, H_MRD, 1'b1, 1'b0);
        bus.in_data  = 'h601;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_err", err_cnt, 0);
        @(posedge clk);
        #1;
        send_pkt(H_MRD, 2, 'h610);
        idle(3);
        chk("t6_rx_p0", rx_cnt[0], 13);

        // Both counters pinned at all-ones.
        for (int i = 0; i < 17; i++) send_beat(DW'('h700 + i), H_UNS, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) send_beat(DW'('h800 + i), H_MRD, 1'b0, 1'b0);
        idle(2);
        chk("t7_drop_sat", drop_cnt, CMAX);
        chk("t7_err_sat", err_cnt, CMAX);
        chk("t7_rx_p0", rx_cnt[0], 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tlp_demux_n.md
# tlp_demux_n

Parametrised N-port TLP demultiplexer, successor to the fixed read/write `tlp_demux`. Sits between the TLP receive stream and the per-class request engines. It decodes Fmt/Type from DW0 of the header on the start-of-packet beat, locks the route for the whole packet, and forwards beats through one registered output slice per packet. Unsupported or unmapped TLPs are discarded and counted.

## Interface
- `PORTS`, 4: number of output ports, 2..4. Class k goes to port k; a class with k ≥ PORTS is dropped.
- `DOUBLE_WORD`, 32: DW width in bits.
- `HEADER_SIZE`, 4*DOUBLE_WORD: header width. DW0 is `hdr[31:0]`.
- `TLP_DATA_WIDTH`, 8*DOUBLE_WORD: payload beat width.
- `CNT_W`, 16: width of the drop and error counters.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: admit new packets. Sampled only in IDLE.
- `in_data`, in, TLP_DATA_WIDTH: input beat payload.
- `in_hdr`, in, HEADER_SIZE: header. Valid on sop beat only.
- `in_sop`, `in_eop`, `in_valid`, in, 1 each: beat framing and valid.
- `in_ready`, out, 1: beat accepted when `in_valid & in_ready`.
- `out_data`, out, PORTS*TLP_DATA_WIDTH: per-port payload. Port p occupies slice p.
- `out_hdr`, out, PORTS*HEADER_SIZE: per-port header, held for the whole packet.
- `out_sop`, `out_eop`, `out_valid`, out, PORTS each: per-port framing and valid.
- `out_ready`, in, PORTS: per-port ready.
- `drop_cnt`, out, CNT_W: saturating count of dropped packets.
- `err_cnt`, out, CNT_W: saturating count of framing errors.

## Operation
- Class decode on the sop beat (fmt = hdr[31:29], type = hdr[28:24]):
  - 0 MRd: fmt 00x, type 00000.
  - 1 MWr: fmt 01x, type 00000.
  - 2 Cpl/CplD: type 01010.
  - 3 Msg: type 10xxx.
  - Anything else is unsupported.
- FSM states: IDLE, FWD, DROP.
  - IDLE, accepted beat with sop:
    - mapped class → FWD, latch `port_sel` and header.
    - unsupported or unmapped → DROP, `drop_cnt`+1.
  - IDLE, accepted beat without sop: discard the beat, `err_cnt`+1, stay in IDLE.
  - sop & eop on the same beat: single-beat packet. Forward or drop it, then return to IDLE.
  - FWD/DROP: an accepted beat with eop returns to IDLE.
  - FWD/DROP, accepted beat with sop: `err_cnt`+1, beat is treated as payload (no re-decode).
- `in_ready`:
  - IDLE: `enable & (!slot_valid | out_ready[port_sel])`.
  - FWD: `!slot_valid | out_ready[port_sel]`.
  - DROP: 1, beats are consumed and discarded.
- Output slot: one register holding data, sop, eop and valid. It is driven onto `out_*[port_sel]` only; other ports show valid = 0. Headers on unselected ports are don't-care.
- Deasserting `enable` mid-packet does not truncate the packet; the FSM blocks only at the next IDLE.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset:
  - FSM → IDLE.
  - all `out_valid`, `out_sop`, `out_eop` = 0.
  - `out_data`/`out_hdr` = 0.
  - counters = 0, `port_sel` = 0.
  - `in_ready` = 0 during the reset cycle.
- Reset mid-packet abandons the packet with no eop emitted. Downstream engines must also reset.
- Latency: 1 cycle from accepted input beat to `out_valid` on the selected port.
- Throughput: 1 beat/cycle when `out_ready[port_sel]` is held high.
- AXI-style handshake:
  - `out_valid`, data, sop and eop stay stable until `out_valid & out_ready`.
  - `out_valid` does not depend combinationally on `out_ready`.
  - `in_ready` may depend combinationally on `out_ready` (pass-through ready).
- Port switch: a new packet for a different port may be accepted in the same cycle the previous eop beat drains from the slot. Ready is taken from the draining port.

## Structure
- Package `tlp_pkg`:
  - class enum (MRD, MWR, CPL, MSG, UNSUP).
  - Fmt/Type bit-position constants.
  - FSM state enum.
  - `function tlp_class(hdr_dw0)`.
- Sub-module `tlp_class_dec`: combinational DW0 → class, one-hot valid. Reused by the transmit side later.
- Top holds the FSM, the output slot, the port mux and the counters.

## Test plan
- PORTS=4, `out_ready`=all 1, MRd 3 beats then MWr 2 beats back-to-back → port0 valid cycles 1..3 with sop@1, eop@3; port1 valid cycles 4..5. `in_ready` held at 1 throughout.
- PORTS=2, CplD 2 beats (hdr[28:24]=01010) → no `out_valid` on any port, `in_ready`=1 every beat, `drop_cnt`=1.
- Port0 `out_ready` toggling 1-cycle-on/4-off over a 4-beat MRd → output beats in order, data stable while stalled, no beat lost or duplicated.
- Beat with `in_valid`=1, sop=0 in IDLE, then sop mid-FWD → `err_cnt`=2, first beat discarded, second beat forwarded as payload.
- Deassert `enable` on beat 2 of a 4-beat MWr → all 4 beats delivered. Next sop sees `in_ready`=0 until `enable`=1.
- `rst`=1 on beat 2 of a 3-beat MRd → next cycle all `out_valid`=0, counters 0. A fresh MRd after reset routes to port0 normally.
